// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : ID-stage per-register latency scoreboard; stalls on RAW/WAW
//            against in-flight results that are not yet forwardable.
// Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 3,
    parameter bit X0_ZERO  = 1'b1,
    parameter int PERF_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic              id_rs1_used,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_wen,
    input  logic [CNT_W-1:0]  id_lat,
    input  logic              flush,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              ctrl_bubble,
    output logic              raw_stall,
    output logic              waw_stall,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [REG_AW-1:0] c_reg_zero = '0;
    localparam logic [PERF_W-1:0] c_perf_max = '1;

    logic [CNT_W-1:0]  r_cnt [NUM_REGS];
    logic [PERF_W-1:0] r_stall_cycles;

    logic [CNT_W-1:0]  w_rs1_cnt;
    logic [CNT_W-1:0]  w_rs2_cnt;
    logic [CNT_W-1:0]  w_rd_cnt;
    logic              w_rs1_live;
    logic              w_rs2_live;
    logic              w_rd_live;
    logic              w_raw;
    logic              w_waw;
    logic              w_stall;
    logic              w_issue;

    // Explicit compare-select keeps lookups in range for any NUM_REGS.
    always_comb begin
        w_rs1_cnt = '0;
        w_rs2_cnt = '0;
        w_rd_cnt  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (id_rs1 == REG_AW'(i)) w_rs1_cnt = r_cnt[i];
            if (id_rs2 == REG_AW'(i)) w_rs2_cnt = r_cnt[i];
            if (id_rd  == REG_AW'(i)) w_rd_cnt  = r_cnt[i];
        end
    end

    assign w_rs1_live = !X0_ZERO || (id_rs1 != c_reg_zero);
    assign w_rs2_live = !X0_ZERO || (id_rs2 != c_reg_zero);
    assign w_rd_live  = !X0_ZERO || (id_rd  != c_reg_zero);

    assign w_raw = id_valid &&
                   ((id_rs1_used && w_rs1_live && (w_rs1_cnt != '0)) ||
                    (id_rs2_used && w_rs2_live && (w_rs2_cnt != '0)));

    // A new writer may only issue once it cannot complete before the older one.
    assign w_waw = id_valid && id_rd_wen && w_rd_live && (w_rd_cnt > id_lat);

    assign w_stall = (w_raw || w_waw) && !flush;
    assign w_issue = id_valid && !w_stall && !flush && id_rd_wen && w_rd_live;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_issue && (id_rd == REG_AW'(i))) begin
                    r_cnt[i] <= id_lat;
                end else if (r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != c_perf_max)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign pc_write     = !w_stall;
    assign if_id_write  = !w_stall;
    assign ctrl_bubble  = w_stall || flush;
    assign raw_stall    = w_raw && !flush;
    assign waw_stall    = w_waw && !flush;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : self-checking bench for hazard_scoreboard (PERF_W=4 instance).
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wen;
        logic [2:0] lat;
        logic       fl;
    } ins_t;

    typedef struct packed {
        logic       pw;
        logic       ifw;
        logic       bub;
        logic       raw;
        logic       waw;
        logic [3:0] sc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic       id_rs1_used;
    logic [4:0] id_rs2;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_rd_wen;
    logic [2:0] id_lat;
    logic       flush;
    logic       pc_write;
    logic       if_id_write;
    logic       ctrl_bubble;
    logic       raw_stall;
    logic       waw_stall;
    logic [3:0] stall_cycles;

    exp_t       exp_q [$];
    logic [2:0] m_cnt [32];
    logic [3:0] m_sc;
    int         n_checks = 0;
    int         n_pass   = 0;
    string      cur_test = "init";
    logic       pw;

    localparam ins_t c_nop = '0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_REGS (32),
        .REG_AW   (5),
        .CNT_W    (3),
        .X0_ZERO  (1'b1),
        .PERF_W   (4)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs1_used  (id_rs1_used),
        .id_rs2       (id_rs2),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_rd_wen    (id_rd_wen),
        .id_lat       (id_lat),
        .flush        (flush),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .ctrl_bubble  (ctrl_bubble),
        .raw_stall    (raw_stall),
        .waw_stall    (waw_stall),
        .stall_cycles (stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s.%s: got %0h expected %0h", cur_test, tag, obs, expv);
    endtask

    function automatic ins_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                input logic u2, input logic [4:0] rd, input logic wen,
                                input logic [2:0] lat, input logic fl);
        ins_t t;
        t.v = 1'b1; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.rd = rd; t.wen = wen; t.lat = lat; t.fl = fl;
        return t;
    endfunction

    function automatic logic pend(input logic [4:0] r);
        return (r != 5'd0) && (m_cnt[r] != 3'd0);
    endfunction

    // Drive one ID cycle, predict outputs, compare mid-cycle, then advance the model.
    task automatic step(input ins_t in, input logic r, output logic pw_o);
        exp_t e;
        logic raw, waw, stall;
        rst = r; id_valid = in.v; id_rs1 = in.rs1; id_rs1_used = in.u1;
        id_rs2 = in.rs2; id_rs2_used = in.u2; id_rd = in.rd; id_rd_wen = in.wen;
        id_lat = in.lat; flush = in.fl;
        raw   = in.v && ((in.u1 && pend(in.rs1)) || (in.u2 && pend(in.rs2)));
        waw   = in.v && in.wen && (in.rd != 5'd0) && (m_cnt[in.rd] > in.lat);
        stall = (raw || waw) && !in.fl;
        e.pw = !stall; e.ifw = !stall; e.bub = stall || in.fl;
        e.raw = raw && !in.fl; e.waw = waw && !in.fl; e.sc = m_sc;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        check("pc_write", pc_write, e.pw);
        check("if_id_write", if_id_write, e.ifw);
        check("ctrl_bubble", ctrl_bubble, e.bub);
        check("raw_stall", raw_stall, e.raw);
        check("waw_stall", waw_stall, e.waw);
        check("stall_cycles", stall_cycles, e.sc);
        pw_o = pc_write;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 3'd0;
            m_sc = 4'd0;
        end else begin
            for (int i = 0; i < 32; i++) if (m_cnt[i] != 3'd0) m_cnt[i] = m_cnt[i] - 3'd1;
            if (in.v && !stall && !in.fl && in.wen && (in.rd != 5'd0)) m_cnt[in.rd] = in.lat;
            if (stall && (m_sc != 4'hf)) m_sc = m_sc + 4'd1;
        end
        #1;
    endtask

    // Re-present the same instruction until it issues; compare the stall length.
    task automatic hold(input ins_t in, input int exp_stalls, input string tag);
        logic p;
        int   n = 0;
        step(in, 1'b0, p);
        while (!p && n < 20) begin
            n++;
            step(in, 1'b0, p);
        end
        check(tag, n, exp_stalls);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
        id_rd = 0; id_rd_wen = 0; id_lat = 0; flush = 0;
        for (int i = 0; i < 32; i++) m_cnt[i] = 3'd0;
        m_sc = 4'd0;
        @(posedge clk); @(posedge clk); #1;

        cur_test = "reset";
        step(c_nop, 1'b0, pw);
        check("pc_write_after_reset", pw, 1);

        cur_test = "t1_load_use";
        step(c_nop, 1'b1, pw);
        step(mk(5'd1, 1, 5'd0, 0, 5'd5, 1, 3'd1, 0), 1'b0, pw);
        hold(mk(5'd5, 1, 5'd1, 1, 5'd6, 1, 3'd0, 0), 1, "stall_len");
        check("sc_total", stall_cycles, 1);

        cur_test = "t2_mul";
        step(c_nop, 1'b1, pw);
        step(mk(5'd2, 1, 5'd3, 1, 5'd7, 1, 3'd4, 0), 1'b0, pw);
        hold(mk(5'd1, 1, 5'd7, 1, 5'd11, 1, 3'd0, 0), 4, "stall_len");
        check("sc_total", stall_cycles, 4);
        step(mk(5'd2, 1, 5'd3, 1, 5'd7, 1, 3'd4, 0), 1'b0, pw);
        step(mk(5'd1, 1, 5'd2, 1, 5'd10, 1, 3'd0, 0), 1'b0, pw);
        check("indep_no_stall", pw, 1);
        hold(mk(5'd7, 1, 5'd0, 0, 5'd12, 1, 3'd0, 0), 3, "stall_len_late");

        cur_test = "t3_unused";
        step(c_nop, 1'b1, pw);
        step(mk(5'd1, 1, 5'd0, 0, 5'd5, 1, 3'd3, 0), 1'b0, pw);
        step(mk(5'd0, 1, 5'd5, 0, 5'd8, 1, 3'd0, 0), 1'b0, pw);
        check("rs2_unused", pw, 1);
        step(mk(5'd5, 0, 5'd0, 0, 5'd13, 0, 3'd0, 0), 1'b0, pw);
        check("rs1_unused", pw, 1);
        step(mk(5'd1, 1, 5'd0, 0, 5'd0, 1, 3'd3, 0), 1'b0, pw);
        step(mk(5'd0, 1, 5'd0, 1, 5'd14, 1, 3'd0, 0), 1'b0, pw);
        check("x0_read", pw, 1);

        cur_test = "t4_waw";
        step(c_nop, 1'b1, pw);
        step(mk(5'd1, 1, 5'd2, 1, 5'd9, 1, 3'd5, 0), 1'b0, pw);
        hold(mk(5'd1, 1, 5'd2, 1, 5'd9, 1, 3'd0, 0), 5, "waw_len");
        step(mk(5'd1, 1, 5'd2, 1, 5'd10, 1, 3'd5, 0), 1'b0, pw);
        step(c_nop, 1'b0, pw);
        step(c_nop, 1'b0, pw);
        step(mk(5'd1, 1, 5'd2, 1, 5'd10, 1, 3'd7, 0), 1'b0, pw);
        check("long_over_short", pw, 1);
        step(mk(5'd1, 1, 5'd2, 1, 5'd9, 1, 3'd5, 0), 1'b0, pw);
        step(mk(5'd9, 1, 5'd0, 0, 5'd9, 1, 3'd0, 0), 1'b0, pw);
        check("raw_and_waw", {raw_stall, waw_stall}, 2'b11);

        cur_test = "t5_flush";
        step(c_nop, 1'b1, pw);
        step(mk(5'd1, 1, 5'd0, 0, 5'd5, 1, 3'd3, 0), 1'b0, pw);
        step(mk(5'd5, 1, 5'd0, 0, 5'd15, 1, 3'd0, 1), 1'b0, pw);
        check("flush_pw", pw, 1);
        hold(mk(5'd5, 1, 5'd0, 0, 5'd15, 1, 3'd0, 0), 2, "after_flush_len");

        cur_test = "t6_reset";
        step(c_nop, 1'b1, pw);
        step(mk(5'd2, 1, 5'd3, 1, 5'd7, 1, 3'd4, 0), 1'b0, pw);
        step(mk(5'd7, 1, 5'd0, 0, 5'd16, 1, 3'd0, 0), 1'b0, pw);
        step(mk(5'd7, 1, 5'd0, 0, 5'd16, 1, 3'd0, 0), 1'b0, pw);
        step(mk(5'd7, 1, 5'd0, 0, 5'd16, 1, 3'd0, 0), 1'b1, pw);
        step(mk(5'd7, 1, 5'd0, 0, 5'd16, 1, 3'd0, 0), 1'b0, pw);
        check("pw_post_reset", pw, 1);
        check("sc_post_reset", stall_cycles, 0);

        cur_test = "t6_saturate";
        step(c_nop, 1'b1, pw);
        for (int k = 0; k < 3; k++) begin
            step(mk(5'd1, 1, 5'd0, 0, 5'd3, 1, 3'd7, 0), 1'b0, pw);
            hold(mk(5'd3, 1, 5'd0, 0, 5'd4, 1, 3'd0, 0), 7, "stall_len");
        end
        check("sc_saturated", stall_cycles, 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
